ipv4_rx_filter: RTL and testbench
=================================

# ipv4_rx_filter

Parametrised successor to the single-address IPv4 header parser. It sits between the Ethernet frame receiver and the transport-layer parser. It accepts any of `NUM_ADDRS` destination addresses and any of `NUM_PROTOS` protocols, and rejects fragments and malformed headers. It emits per-frame metadata and a coded error, and forwards only the IPv4 payload bytes.

## Interface
- `NUM_ADDRS`, 2: number of accepted destination addresses (1..8).
- `IP_ADDRESSES`, {32'hC0A8010A, 32'h0A000002}: packed `[NUM_ADDRS*32-1:0]`; entry i is bits [32i+31:32i].
- `NUM_PROTOS`, 2: number of accepted protocol numbers (1..4).
- `PROTOCOLS`, {8'd17, 8'd6}: packed `[NUM_PROTOS*8-1:0]`; entry i is bits [8i+7:8i].
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `eth_data_in` in 8 (`byte_t`): frame byte from the Ethernet receiver.
- `eth_byte_valid` in 1: `eth_data_in` is valid this cycle.
- `eth_eof` in 1: qualified by `eth_byte_valid`; marks the last byte of the frame.
- `eth_err` in 1: qualified by `eth_eof`; reports an upstream frame error.
- `ip_data_out` out 8: payload byte.
- `ip_byte_valid` out 1: `ip_data_out` is valid.
- `ip_eof` out 1: one-cycle end-of-frame pulse, exactly one per input frame.
- `ip_err` out 1: asserted only together with `ip_eof`; the frame is bad.
- `ip_err_code` out 3 (`ip_err_t`): valid with `ip_eof`. Codes:
  - 0 NONE
  - 1 VERSION
  - 2 IHL
  - 3 FRAG
  - 4 PROTO
  - 5 ADDR
  - 6 CSUM
  - 7 FRAME
- `meta_valid` out 1: one-cycle pulse when a header has been accepted.
- `meta_src_addr` out 32: source address. Held until the next `meta_valid`.
- `meta_proto` out 8: protocol byte. Held.
- `meta_addr_idx` out max(1,$clog2(NUM_ADDRS)): index of the lowest matching `IP_ADDRESSES` entry. Held.
- `meta_payload_len` out 16: total_len − 4·IHL. Held.

## Operation
- FSM states: `HEADER`, `PAYLOAD`, `DROP`.
- Only cycles with `eth_byte_valid`=1 advance any state. Bytes with `eth_byte_valid`=0 are ignored.
- `HEADER` checks, by byte count `hdr_cnt` (0-based). The first failing check sets its code and moves the FSM to `DROP`.
  - Byte 0: version ≠ 4 → VERSION. IHL < 5 → IHL.
  - Bytes 2–3: total_len.
  - Bytes 6–7: MF=1 or fragment offset ≠ 0 → FRAG. DF is ignored.
  - Byte 9: no match in `PROTOCOLS` → PROTO.
  - Bytes 12–15: source address.
  - Byte 19: full destination matches no entry → ADDR.
- At byte 4·IHL−1 (options are skipped, not interpreted):
  - total_len < 4·IHL → FRAME.
  - Otherwise, running one's-complement sum ≠ 16'hFFFF → CSUM.
  - Otherwise pulse `meta_valid`, load the metadata, set `rem` = payload length, and go to `PAYLOAD`.
- `PAYLOAD`:
  - While `rem` > 0: forward the byte and decrement `rem`.
  - Bytes with `rem` = 0 are padding; drop them silently.
- `eth_eof` in any state ends the frame, pulses `ip_eof`, and returns the FSM to `HEADER` with `hdr_cnt`=0 and the checksum cleared. `ip_err_code` on that pulse:
  - FRAME if `eth_eof` arrives in `HEADER`.
  - FRAME if `rem` > 1 at `eth_eof` in `PAYLOAD` (truncated frame).
  - FRAME if `eth_err`=1.
  - Otherwise the latched code, or NONE.
- Error priority is first detected wins, with one exception: `eth_err` overrides NONE only.
- Frames rejected in `HEADER` never produce `ip_byte_valid` or `meta_valid`.
- Zero-length payload: `meta_valid` pulses, then `ip_eof` arrives with no data bytes.

## Timing
- Reset values: all outputs 0, `ip_err_code`=NONE, state `HEADER`, `hdr_cnt`=0, checksum cleared.
- Latency: exactly 1 cycle from an input byte to its `ip_data_out`/`ip_byte_valid`.
- `meta_valid` pulses 1 cycle after the last header byte. It therefore always precedes the first payload `ip_byte_valid` by at least 1 cycle.
- `ip_eof` pulses 1 cycle after the `eth_eof` byte.
  - If that byte is forwarded, `ip_eof` coincides with its `ip_byte_valid`.
  - If `eth_eof` is on the last header byte of a valid zero-payload frame, `meta_valid` and `ip_eof` coincide.
- A new frame's byte 0 may arrive on the cycle immediately after the `eth_eof` byte. No gap is required.
- `rst` mid-frame: all state returns to reset values on the next edge and no `ip_eof` is emitted. The remaining bytes of the interrupted frame are parsed as a new header; they typically end with VERSION.

## Configuration
- `IPV4_RX_CSUM_EN` defined: the checksum accumulator is instantiated and CSUM errors are reported.
- Not defined: no accumulator, the CSUM code is never produced, and all other behaviour is identical.

## Structure
- `eth_pkg` gains:
  - `ip_err_t` (3-bit enum above)
  - `IPV4_VERSION`=4
  - `IPV4_MIN_IHL`=5
  - `MAX_IP_HEADER_LEN`=60
  - `byte_t`, which is already present
- Sub-module `ipv4_csum_accum`:
  - Sync active-high `rst`, `clr`, `en`, byte input.
  - 16-bit end-around-carry sum over byte pairs, high byte first.
  - Result is combinational.

## Test plan
- Valid UDP frame: IHL=5, total_len=28, dst 192.168.1.10, 8 payload bytes, 0x00 padding to 46 → `meta_valid` with idx=0, proto=17, len=8. Exactly 8 bytes forwarded, 1 cycle latency. `ip_eof` with code NONE.
- Same frame to 10.0.0.2 with protocol 6 and IHL=6 (one option word) → idx=1, proto=6, payload forwarded starting at byte 24.
- Individual header faults: version=6 → VERSION; IHL=4 → IHL; MF=1 → FRAG; protocol=1 → PROTO; dst 10.0.0.3 → ADDR; corrupted checksum → CSUM. Each gives zero data and a single `ip_eof`+`ip_err`.
- total_len=100 with `eth_eof` after 20 payload bytes → FRAME. Separately, a valid frame with `eth_err`=1 on its last byte → FRAME.
- Back-to-back frames with no gap, with `eth_byte_valid` deasserted randomly mid-frame → both frames parsed correctly.
- `rst` pulsed at header byte 10, followed by a fresh valid frame → no `ip_eof` for the aborted frame; the new frame is accepted.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4 receive-path types and constants.
//   byte_t      : one octet on the receive byte streams
//   ip_err_t    : coded frame error reported with ip_eof
//   rx_state_t  : ipv4_rx_filter parser state
package eth_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_VERSION = 3'd1,
    ERR_IHL     = 3'd2,
    ERR_FRAG    = 3'd3,
    ERR_PROTO   = 3'd4,
    ERR_ADDR    = 3'd5,
    ERR_CSUM    = 3'd6,
    ERR_FRAME   = 3'd7
  } ip_err_t;

  typedef enum logic [1:0] {
    HEADER  = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } rx_state_t;

  localparam logic [3:0] IPV4_VERSION      = 4'd4;
  localparam logic [3:0] IPV4_MIN_IHL      = 4'd5;
  localparam int         MAX_IP_HEADER_LEN = 60;

endpackage

// File: rtl/ipv4_csum_accum.sv
// Running 16-bit one's-complement sum over a byte stream, taken as
// big-endian byte pairs (high byte first).
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the sum (wins over en)
//   en       : data is a valid stream byte this cycle
//   data     : stream byte
//   sum      : combinational; includes the pair completed by data this cycle
module ipv4_csum_accum
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  byte_t       data,
  output logic [15:0] sum
);

  logic [15:0] acc;
  byte_t       hi_byte;
  logic        odd;
  logic [16:0] add;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    add = {1'b0, acc} + {1'b0, hi_byte, data};
    sum = acc;
    // End-around carry; a second carry cannot occur.
    if (en && odd) sum = add[15:0] + {15'd0, add[16]};
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst || clr) begin
      acc     <= '0;
      hi_byte <= '0;
      odd     <= 1'b0;
    end else if (en) begin
      if (odd) acc     <= sum;
      else     hi_byte <= data;
      odd <= ~odd;
    end
  end

endmodule

// File: rtl/ipv4_rx_filter.sv
// IPv4 receive filter: parses the header from the Ethernet byte stream,
// accepts NUM_ADDRS destinations and NUM_PROTOS protocols, rejects fragments
// and malformed headers, forwards payload bytes only, and reports per-frame
// metadata plus a coded error on the end-of-frame pulse.
// Build option: define IPV4_RX_CSUM_EN to check the header checksum (CSUM).
// Ports:
//   clk, rst                           : clock, synchronous active-high reset
//   eth_data_in/eth_byte_valid         : input byte stream
//   eth_eof, eth_err                   : last byte of frame / upstream error
//   ip_data_out/ip_byte_valid          : forwarded payload (1-cycle latency)
//   ip_eof, ip_err, ip_err_code        : end-of-frame pulse with status
//   meta_valid + meta_*                : accepted-header metadata (held)
module ipv4_rx_filter
  import eth_pkg::*;
#(
  parameter int                      NUM_ADDRS    = 2,
  parameter logic [NUM_ADDRS*32-1:0] IP_ADDRESSES = {32'hC0A8010A, 32'h0A000002},
  parameter int                      NUM_PROTOS   = 2,
  parameter logic [NUM_PROTOS*8-1:0] PROTOCOLS    = {8'd17, 8'd6}
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  byte_t                                        eth_data_in,
  input  logic                                         eth_byte_valid,
  input  logic                                         eth_eof,
  input  logic                                         eth_err,
  output byte_t                                        ip_data_out,
  output logic                                         ip_byte_valid,
  output logic                                         ip_eof,
  output logic                                         ip_err,
  output ip_err_t                                      ip_err_code,
  output logic                                         meta_valid,
  output logic [31:0]                                  meta_src_addr,
  output logic [7:0]                                   meta_proto,
  output logic [((NUM_ADDRS > 1) ? $clog2(NUM_ADDRS) : 1)-1:0] meta_addr_idx,
  output logic [15:0]                                  meta_payload_len
);

  localparam int AIW = (NUM_ADDRS > 1) ? $clog2(NUM_ADDRS) : 1;

  rx_state_t      state;
  logic [5:0]     hdr_cnt;     // header byte index, 0..59
  logic [3:0]     ihl;
  logic [15:0]    total_len;
  logic [15:0]    rem;         // payload bytes still to forward
  logic [31:0]    src_addr;
  byte_t          proto;
  logic [23:0]    dst_hi;      // destination bytes 16..18
  logic [AIW-1:0] addr_idx;
  ip_err_t        err_code;    // latched first header error

  logic           proto_hit, addr_hit, csum_ok;
  logic [AIW-1:0] hit_idx;
  logic [31:0]    dst_addr;
  logic [5:0]     hdr_len;
  logic [15:0]    payload_len;
  logic           hdr_last, hdr_accept;
  ip_err_t        hdr_err, eof_code;

  assign dst_addr    = {dst_hi, eth_data_in};
  assign hdr_len     = {ihl, 2'b00};
  assign payload_len = total_len - {10'd0, hdr_len};
  // ihl is only valid once byte 0 has been taken.
  assign hdr_last    = (hdr_cnt != 6'd0) && (hdr_cnt == hdr_len - 6'd1);
  assign hdr_accept  = hdr_last && (hdr_err == ERR_NONE);

`ifdef IPV4_RX_CSUM_EN
  logic [15:0] csum_sum;

  ipv4_csum_accum u_csum (
    .clk  (clk),
    .rst  (rst),
    .clr  (eth_byte_valid && eth_eof),
    .en   (eth_byte_valid && (state == HEADER)),
    .data (eth_data_in),
    .sum  (csum_sum)
  );

  assign csum_ok = (csum_sum == 16'hFFFF);
`else
  assign csum_ok = 1'b1;
`endif

  always_comb begin
    proto_hit = 1'b0;
    for (int i = 0; i < NUM_PROTOS; i++)
      if (eth_data_in == PROTOCOLS[8*i +: 8]) proto_hit = 1'b1;
  end

  // Scan downwards so the lowest matching entry wins.
  always_comb begin
    addr_hit = 1'b0;
    hit_idx  = '0;
    for (int i = NUM_ADDRS - 1; i >= 0; i--)
      if (dst_addr == IP_ADDRESSES[32*i +: 32]) begin
        addr_hit = 1'b1;
        hit_idx  = AIW'(i);
      end
  end

  // Check applied to the current header byte; the first failure wins.
  always_comb begin
    hdr_err = ERR_NONE;
    case (hdr_cnt)
      6'd0: begin
        if (eth_data_in[7:4] != IPV4_VERSION)     hdr_err = ERR_VERSION;
        else if (eth_data_in[3:0] < IPV4_MIN_IHL) hdr_err = ERR_IHL;
      end
      6'd6:  if (eth_data_in[5:0] != 6'd0) hdr_err = ERR_FRAG;  // MF + offset[12:8]
      6'd7:  if (eth_data_in != 8'd0)      hdr_err = ERR_FRAG;  // offset[7:0]
      6'd9:  if (!proto_hit)               hdr_err = ERR_PROTO;
      6'd19: if (!addr_hit)                hdr_err = ERR_ADDR;
      default: ;
    endcase
    if (hdr_err == ERR_NONE && hdr_last) begin
      if (total_len < {10'd0, hdr_len}) hdr_err = ERR_FRAME;
      else if (!csum_ok)                hdr_err = ERR_CSUM;
    end
  end

  // Status reported if the current byte ends the frame.
  always_comb begin
    eof_code = err_code;
    case (state)
      HEADER: begin
        if (hdr_err != ERR_NONE) eof_code = hdr_err;
        else if (!hdr_accept)    eof_code = ERR_FRAME;
      end
      PAYLOAD: if (rem > 16'd1) eof_code = ERR_FRAME;
      default: ;
    endcase
    // Upstream error never masks an earlier, more specific code.
    if (eof_code == ERR_NONE && eth_err) eof_code = ERR_FRAME;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= HEADER;
      hdr_cnt          <= '0;
      ihl              <= '0;
      total_len        <= '0;
      rem              <= '0;
      src_addr         <= '0;
      proto            <= '0;
      dst_hi           <= '0;
      addr_idx         <= '0;
      err_code         <= ERR_NONE;
      ip_data_out      <= '0;
      ip_byte_valid    <= 1'b0;
      ip_eof           <= 1'b0;
      ip_err           <= 1'b0;
      ip_err_code      <= ERR_NONE;
      meta_valid       <= 1'b0;
      meta_src_addr    <= '0;
      meta_proto       <= '0;
      meta_addr_idx    <= '0;
      meta_payload_len <= '0;
    end else begin
      ip_byte_valid <= 1'b0;
      ip_eof        <= 1'b0;
      ip_err        <= 1'b0;
      ip_err_code   <= ERR_NONE;
      meta_valid    <= 1'b0;

      if (eth_byte_valid) begin
        unique case (state)
          HEADER: begin
            case (hdr_cnt)
              6'd0:                      ihl             <= eth_data_in[3:0];
              6'd2:                      total_len[15:8] <= eth_data_in;
              6'd3:                      total_len[7:0]  <= eth_data_in;
              6'd9:                      proto           <= eth_data_in;
              6'd12, 6'd13, 6'd14, 6'd15: src_addr       <= {src_addr[23:0], eth_data_in};
              6'd16, 6'd17, 6'd18:       dst_hi          <= {dst_hi[15:0], eth_data_in};
              6'd19:                     addr_idx        <= hit_idx;
              default: ;
            endcase
            hdr_cnt <= hdr_cnt + 6'd1;
            if (hdr_err != ERR_NONE) begin
              state    <= DROP;
              err_code <= hdr_err;
            end else if (hdr_accept) begin
              meta_valid       <= 1'b1;
              meta_src_addr    <= src_addr;
              meta_proto       <= proto;
              // On IHL=5 the index is resolved on this very byte.
              meta_addr_idx    <= (hdr_cnt == 6'd19) ? hit_idx : addr_idx;
              meta_payload_len <= payload_len;
              rem              <= payload_len;
              state            <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            // Bytes past the IPv4 length are Ethernet padding.
            if (rem != 16'd0) begin
              ip_data_out   <= eth_data_in;
              ip_byte_valid <= 1'b1;
              rem           <= rem - 16'd1;
            end
          end
          DROP: ;
        endcase

        if (eth_eof) begin
          ip_eof      <= 1'b1;
          ip_err      <= (eof_code != ERR_NONE);
          ip_err_code <= eof_code;
          state       <= HEADER;
          hdr_cnt     <= '0;
          err_code    <= ERR_NONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ipv4_rx_filter.sv
// Directed self-checking bench for ipv4_rx_filter. Address entry 0 is set to
// 192.168.1.10 and entry 1 to 10.0.0.2.
module tb_ipv4_rx_filter;
  import eth_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  byte_t       eth_data_in;
  logic        eth_byte_valid, eth_eof, eth_err;
  byte_t       ip_data_out;
  logic        ip_byte_valid, ip_eof, ip_err;
  ip_err_t     ip_err_code;
  logic        meta_valid;
  logic [31:0] meta_src_addr;
  logic [7:0]  meta_proto;
  logic [0:0]  meta_addr_idx;
  logic [15:0] meta_payload_len;

  ipv4_rx_filter #(
    .NUM_ADDRS    (2),
    .IP_ADDRESSES ({32'h0A000002, 32'hC0A8010A}),
    .NUM_PROTOS   (2),
    .PROTOCOLS    ({8'd17, 8'd6})
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .eth_data_in      (eth_data_in),
    .eth_byte_valid   (eth_byte_valid),
    .eth_eof          (eth_eof),
    .eth_err          (eth_err),
    .ip_data_out      (ip_data_out),
    .ip_byte_valid    (ip_byte_valid),
    .ip_eof           (ip_eof),
    .ip_err           (ip_err),
    .ip_err_code      (ip_err_code),
    .meta_valid       (meta_valid),
    .meta_src_addr    (meta_src_addr),
    .meta_proto       (meta_proto),
    .meta_addr_idx    (meta_addr_idx),
    .meta_payload_len (meta_payload_len)
  );

  localparam logic [31:0] SRC_IP = 32'hC0A80001;
  localparam logic [31:0] DST_A  = 32'hC0A8010A;
  localparam logic [31:0] DST_B  = 32'h0A000002;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  byte_t   out_q[$];
  int      out_cyc[$];
  ip_err_t eof_code_q[$];
  bit      eof_err_q[$];
  int      meta_cnt = 0, meta_cyc = 0, eof_cyc = 0, stray_err = 0;

  always @(negedge clk) begin
    if (ip_byte_valid) begin
      out_q.push_back(ip_data_out);
      out_cyc.push_back(cyc);
    end
    if (meta_valid) begin
      meta_cnt++;
      meta_cyc = cyc;
    end
    if (ip_eof) begin
      eof_code_q.push_back(ip_err_code);
      eof_err_q.push_back(ip_err);
      eof_cyc = cyc;
    end
    if (ip_err && !ip_eof) stray_err++;
  end

  byte_t frm[$], pay[$], exp_out[$], a_frm[$], a_pay[$];
  int    s_out, s_eof, s_meta, mark_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [15:0] csum16(input byte_t h[$]);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i + 1 < h.size(); i += 2) s += {16'd0, h[i], h[i+1]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return ~s[15:0];
  endfunction

  task automatic build(input logic [3:0] ver, input logic [3:0] ihl, input logic [15:0] tlen,
                       input logic [15:0] frag, input byte_t prot, input logic [31:0] dst,
                       input bit bad_csum, input int npay, input byte_t seed, input int pad_to);
    byte_t       h[$];
    logic [15:0] cs;
    logic [31:0] src;
    int          hl;
    src = SRC_IP;
    hl  = (ihl < 4'd5) ? 20 : 4 * int'(ihl);
    h.push_back({ver, ihl}); h.push_back(8'h00);
    h.push_back(tlen[15:8]); h.push_back(tlen[7:0]);
    h.push_back(8'h12);      h.push_back(8'h34);
    h.push_back(frag[15:8]); h.push_back(frag[7:0]);
    h.push_back(8'h40);      h.push_back(prot);
    h.push_back(8'h00);      h.push_back(8'h00);
    for (int i = 0; i < 4; i++) h.push_back(src[31-8*i -: 8]);
    for (int i = 0; i < 4; i++) h.push_back(dst[31-8*i -: 8]);
    while (h.size() < hl) h.push_back(8'h00);
    cs = csum16(h);
    if (bad_csum) cs = cs ^ 16'h0001;
    h[10] = cs[15:8];
    h[11] = cs[7:0];
    pay.delete();
    for (int i = 0; i < npay; i++) pay.push_back(seed + byte_t'(i));
    frm = {h, pay};
    while (frm.size() < pad_to) frm.push_back(8'h00);
  endtask

  task automatic mark_start();
    s_out  = out_q.size();
    s_eof  = eof_code_q.size();
    s_meta = meta_cnt;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    eth_byte_valid = 1'b0;
    eth_data_in    = byte_t'($urandom);
    eth_eof        = 1'($urandom);
    eth_err        = 1'($urandom);
  endtask

  // Drive frm; eof on its last byte and optionally on index eof2.
  task automatic send(input bit gaps, input bit err_last, input int mark, input int eof2);
    for (int i = 0; i < frm.size(); i++) begin
      if (gaps) while ($urandom_range(0, 2) == 0) idle();
      @(posedge clk); #1;
      eth_data_in    = frm[i];
      eth_byte_valid = 1'b1;
      eth_eof        = (i == frm.size() - 1) || (i == eof2);
      eth_err        = eth_eof && err_last && (i == frm.size() - 1);
      if (i == mark) mark_cyc = cyc;
    end
    @(posedge clk); #1;
    eth_byte_valid = 1'b0;
    eth_eof        = 1'b0;
    eth_err        = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input int n_eof, input ip_err_t code,
                              input int n_meta, input logic [0:0] idx, input byte_t prot,
                              input logic [15:0] len);
    repeat (4) @(negedge clk);
    check({tag, " eof count"}, eof_code_q.size() - s_eof, n_eof);
    for (int i = s_eof; i < eof_code_q.size(); i++) begin
      check({tag, " err code"}, eof_code_q[i], code);
      check({tag, " err flag"}, eof_err_q[i], code != ERR_NONE);
    end
    check({tag, " meta count"}, meta_cnt - s_meta, n_meta);
    if (n_meta > 0) begin
      check({tag, " meta idx"}, meta_addr_idx, idx);
      check({tag, " meta proto"}, meta_proto, prot);
      check({tag, " meta len"}, meta_payload_len, len);
      check({tag, " meta src"}, meta_src_addr, SRC_IP);
    end
    check({tag, " data count"}, out_q.size() - s_out, exp_out.size());
    for (int i = 0; i < exp_out.size() && s_out + i < out_q.size(); i++)
      check({tag, " data byte"}, out_q[s_out + i], exp_out[i]);
    check({tag, " stray ip_err"}, stray_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    ip_err_t csum_code;
    rst = 1'b1; eth_data_in = '0; eth_byte_valid = 1'b0; eth_eof = 1'b0; eth_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset byte_valid", ip_byte_valid, 0);
    check("reset eof", ip_eof, 0);
    check("reset err", ip_err, 0);
    check("reset err_code", ip_err_code, ERR_NONE);
    check("reset meta_valid", meta_valid, 0);
    check("reset meta_src", meta_src_addr, 0);
    check("reset meta_len", meta_payload_len, 0);

    // Valid UDP frame, padded to 46 bytes.
    build(4, 5, 28, 16'h0000, 17, DST_A, 0, 8, 8'hA0, 46);
    exp_out = pay; mark_start(); send(0, 0, 20, -1);
    expect_frame("udp", 1, ERR_NONE, 1, 0, 17, 8);
    check("udp latency", out_cyc[s_out], mark_cyc + 1);
    check("udp meta first", meta_cyc < out_cyc[s_out], 1);

    // TCP with one option word to the second address; DF is ignored.
    build(4, 6, 32, 16'h4000, 6, DST_B, 0, 8, 8'h50, 46);
    exp_out = pay; mark_start(); send(0, 0, 24, -1);
    expect_frame("ihl6", 1, ERR_NONE, 1, 1, 6, 8);
    check("ihl6 latency", out_cyc[s_out], mark_cyc + 1);

    exp_out.delete();
    build(6, 5, 28, 16'h0000, 17, DST_A, 0, 8, 8'h10, 46);
    mark_start(); send(0, 0, -1, -1);
    expect_frame("version", 1, ERR_VERSION, 0, 0, 0, 0);
    build(4, 4, 28, 16'h0000, 17, DST_A, 0, 8, 8'h10, 46);
    mark_start(); send(0, 0, -1, -1);
    expect_frame("ihl", 1, ERR_IHL, 0, 0, 0, 0);
    build(4, 5, 28, 16'h2000, 17, DST_A, 0, 8, 8'h10, 46);
    mark_start(); send(0, 0, -1, -1);
    expect_frame("frag", 1, ERR_FRAG, 0, 0, 0, 0);
    build(4, 5, 28, 16'h0000, 1, DST_A, 0, 8, 8'h10, 46);
    mark_start(); send(0, 0, -1, -1);
    expect_frame("proto", 1, ERR_PROTO, 0, 0, 0, 0);
    build(4, 5, 28, 16'h0000, 17, 32'h0A000003, 0, 8, 8'h10, 46);
    mark_start(); send(0, 0, -1, -1);
    expect_frame("addr", 1, ERR_ADDR, 0, 0, 0, 0);

    // Corrupted checksum: rejected only when the checker is built in.
    build(4, 5, 28, 16'h0000, 17, DST_A, 1, 8, 8'h70, 46);
    mark_start();
`ifdef IPV4_RX_CSUM_EN
    exp_out.delete(); send(0, 0, -1, -1);
    expect_frame("csum", 1, ERR_CSUM, 0, 0, 0, 0);
`else
    exp_out = pay; send(0, 0, -1, -1);
    expect_frame("csum", 1, ERR_NONE, 1, 0, 17, 8);
`endif

    // Truncated: total_len 100 but only 20 payload bytes arrive.
    build(4, 5, 100, 16'h0000, 17, DST_A, 0, 20, 8'hC0, 0);
    exp_out = pay; mark_start(); send(0, 0, -1, -1);
    expect_frame("truncated", 1, ERR_FRAME, 1, 0, 17, 80);

    // Upstream error on the final padding byte of a valid frame.
    build(4, 5, 28, 16'h0000, 17, DST_A, 0, 8, 8'hE0, 46);
    exp_out = pay; mark_start(); send(0, 1, -1, -1);
    expect_frame("eth_err", 1, ERR_FRAME, 1, 0, 17, 8);

    // Back-to-back frames with random idle cycles.
    build(4, 5, 28, 16'h0000, 17, DST_A, 0, 8, 8'h01, 46);
    a_frm = frm; a_pay = pay;
    build(4, 5, 25, 16'h0000, 6, DST_B, 0, 5, 8'h81, 46);
    frm = {a_frm, frm}; pay = {a_pay, pay};
    exp_out = pay; mark_start(); send(1, 0, -1, a_frm.size() - 1);
    expect_frame("b2b", 2, ERR_NONE, 2, 1, 6, 5);

    // Zero-length payload, eof on the last header byte.
    build(4, 5, 20, 16'h0000, 17, DST_A, 0, 0, 8'h00, 0);
    exp_out.delete(); mark_start(); send(0, 0, -1, -1);
    expect_frame("zero len", 1, ERR_NONE, 1, 0, 17, 0);
    check("zero len meta with eof", meta_cyc, eof_cyc);

    // Reset after header byte 9, then a fresh valid frame.
    build(4, 5, 28, 16'h0000, 17, DST_A, 0, 8, 8'h33, 46);
    mark_start();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      eth_data_in = frm[i]; eth_byte_valid = 1'b1;
    end
    @(posedge clk); #1; eth_byte_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("mid rst eof", ip_eof, 0);
    build(4, 5, 28, 16'h0000, 6, DST_B, 0, 8, 8'h44, 46);
    exp_out = pay; send(0, 0, -1, -1);
    expect_frame("after rst", 1, ERR_NONE, 1, 1, 6, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
